// File: rtl/frame_accumulator.sv
// ---------------------------------------------------------------------------
// frame_accumulator
//   Sums signed 32-bit samples from the upstream a*b+c*d+e datapath into
//   frames. A frame closes after FRAME_LEN beats or on an early in_last beat.
//   One {sum, beat count, sat} result per frame is offered over valid/ready.
//
// Parameters
//   FRAME_LEN  beats per full frame (1..255)
//   ACC_W      accumulator / result width (>= 32 + clog2(FRAME_LEN))
//   CNT_W      beat counter width (>= clog2(FRAME_LEN+1))
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-high
//   in_valid   upstream beat valid
//   in_ready   beat can be accepted this cycle
//   in_y       signed sample
//   in_last    closes the frame early (qualified by in_valid)
//   out_valid  frame result valid
//   out_ready  downstream accepts result
//   out_sum    signed frame sum
//   out_count  beats in the frame (1..FRAME_LEN)
//   out_sat    result was clamped to the signed 32-bit range
//
// Build option
//   FRAME_ACC_SAT_EN  when defined, results are clamped to [-2^31, 2^31-1]
//                     and out_sat flags a clamp; otherwise the full-width
//                     sum is emitted and out_sat is always 0.
// ---------------------------------------------------------------------------
module frame_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 40,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [31:0]      in_y,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_sat
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0]        r_out_count;
    logic                    r_out_sat;

    logic                    w_accept;
    logic                    w_close;
    logic signed [ACC_W-1:0] w_y_ext;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0]        w_cnt_next;
    logic signed [ACC_W-1:0] w_res;
    logic                    w_sat;

`ifdef FRAME_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(32'sh7FFF_FFFF);
    localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(32'sh8000_0000);

    // Returns {clamped, value}; clamped is set when the value had to move.
    function automatic logic [ACC_W:0] clamp32(input logic signed [ACC_W-1:0] v);
        if (v > C_MAX) begin
            return {1'b1, C_MAX};
        end else if (v < C_MIN) begin
            return {1'b1, C_MIN};
        end else begin
            return {1'b0, v};
        end
    endfunction

    logic [ACC_W:0] w_clamp;
    assign w_clamp = clamp32(w_sum);
    assign w_sat   = w_clamp[ACC_W];
    assign w_res   = w_clamp[ACC_W-1:0];
`else
    assign w_sat   = 1'b0;
    assign w_res   = w_sum;
`endif

    // A pending result that is not being taken blocks every beat, closing or not.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    assign w_y_ext    = ACC_W'(in_y);
    // In IDLE the accumulator is logically empty, so the first beat loads directly.
    assign w_base     = (r_state == IDLE) ? '0 : r_acc;
    assign w_sum      = w_base + w_y_ext;
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_close    = in_last || (w_cnt_next == CNT_W'(FRAME_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_close) begin
                    // A new result overrides the clear above: back-to-back frames with no bubble.
                    r_out_valid <= 1'b1;
                    r_out_sum   <= w_res;
                    r_out_count <= w_cnt_next;
                    r_out_sat   <= w_sat;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_state     <= IDLE;
                end else begin
                    r_acc       <= w_sum;
                    r_cnt       <= w_cnt_next;
                    r_state     <= ACCUM;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_frame_accumulator.sv
module tb_frame_accumulator;

    localparam int FRAME_LEN = 8;
    localparam int ACC_W     = 40;
    localparam int CNT_W     = 8;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [31:0]      in_y;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0]        out_count;
    logic                    out_sat;

    frame_accumulator #(
        .FRAME_LEN(FRAME_LEN),
        .ACC_W    (ACC_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_y     (in_y),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_sat  (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [63:0] sum;
        logic [63:0]        cnt;
        logic               sat;
        int                 cyc;
    } res_t;

    res_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   vld_cycles = 0;
    int   ready_low = 0;
    int   last_cyc = 0;

    // Observes the output handshake at each active edge.
    always @(posedge clk) begin : mon
        res_t r;
        cyc = cyc + 1;
        if (!rst) begin
            if (out_valid) vld_cycles = vld_cycles + 1;
            if (!in_ready) ready_low = ready_low + 1;
            if (out_valid && out_ready) begin
                r.sum = out_sum;
                r.cnt = 64'(out_count);
                r.sat = out_sat;
                r.cyc = cyc;
                q.push_back(r);
            end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [31:0] y, input logic last);
        int k;
        in_valid = 1'b1;
        in_y     = y;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (k == 100) chk("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic signed [63:0] sum,
                                 input logic [63:0] cnt, input logic sat);
        int   k;
        res_t r;
        k = 0;
        while (q.size() == 0 && k < 50) begin
            tick();
            k++;
        end
        if (q.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            r = q.pop_front();
            last_cyc = r.cyc;
            chk({tag, "_sum"}, r.sum, sum);
            chk({tag, "_cnt"}, r.cnt, cnt);
            chk({tag, "_sat"}, 64'(r.sat), 64'(sat));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_y      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_sum",   out_sum, 0);
        chk("rst_out_count", 64'(out_count), 0);
        chk("rst_out_sat",   64'(out_sat), 0);
        chk("rst_in_ready",  64'(in_ready), 1);
        rst = 1'b0;
        tick();

        // 1: full frame of 1000s
        vld_cycles = 0;
        for (int i = 0; i < 8; i++) send(1000, 1'b0);
        chk("t1_valid_after_close", 64'(out_valid), 1);
        expect_result("t1", 8000, 8, 1'b0);
        tick();
        tick();
        chk("t1_valid_cycles", vld_cycles, 1);

        // 2: early close, then a fresh frame
        send(5, 1'b0);
        send(-7, 1'b0);
        send(2, 1'b1);
        expect_result("t2a", 0, 3, 1'b0);
        send(10, 1'b0);
        send(20, 1'b1);
        expect_result("t2b", 30, 2, 1'b0);

        // 3: backpressure
        out_ready = 1'b0;
        send(4, 1'b1);
        chk("t3_ready_low", 64'(in_ready), 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_y     = 100 + i;
            in_last  = (i == 3);
            tick();
            chk("t3_stall_ready", 64'(in_ready), 0);
            chk("t3_hold_sum", out_sum, 4);
            chk("t3_hold_cnt", 64'(out_count), 1);
        end
        chk("t3_no_handshake", q.size(), 0);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_ready_comb", 64'(in_ready), 1);
        expect_result("t3", 4, 1, 1'b0);
        send(3, 1'b1);
        expect_result("t3_next", 3, 1, 1'b0);

        // 4: extremes
        for (int i = 0; i < 8; i++) send(32'sh7FFF_FFFF, 1'b0);
`ifdef FRAME_ACC_SAT_EN
        expect_result("t4_max", 2147483647, 8, 1'b1);
`else
        expect_result("t4_max", 64'sd17179869176, 8, 1'b0);
`endif
        for (int i = 0; i < 8; i++) send(32'sh8000_0000, 1'b0);
`ifdef FRAME_ACC_SAT_EN
        expect_result("t4_min", -64'sd2147483648, 8, 1'b1);
`else
        expect_result("t4_min", -64'sd17179869184, 8, 1'b0);
`endif

        // 5: reset aborts a partial frame
        for (int i = 0; i < 3; i++) send(9, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid_after_rst", 64'(out_valid), 0);
        for (int i = 0; i < 8; i++) send(1, 1'b0);
        expect_result("t5", 8, 8, 1'b0);
        tick();
        tick();
        chk("t5_no_extra", q.size(), 0);

        // 6: continuous stream
        ready_low = 0;
        for (int i = 1; i <= 24; i++) send(i, 1'b0);
        expect_result("t6a", 36, 8, 1'b0);
        c0 = last_cyc;
        expect_result("t6b", 100, 8, 1'b0);
        chk("t6_gap1", last_cyc - c0, 8);
        c0 = last_cyc;
        expect_result("t6c", 164, 8, 1'b0);
        chk("t6_gap2", last_cyc - c0, 8);
        chk("t6_ready_low", ready_low, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
